// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle sequencer for the MIPS datapath. A Moore FSM steps each
// instruction through fetch, decode, execute, memory and writeback and drives
// the shared ALU, the unified instruction/data memory port, the IR, the
// register file and the PC. Memory states stall on the mem_ready handshake.
// ALU function codes match the single-cycle control unit.
//
// Configuration macro:
//   MC_ILLEGAL_TRAP_EN  defined   : illegal opcode in DECODE -> HALT (trap=1,
//                                   all strobes 0, left only by rst)
//                       undefined : illegal opcode runs as a NOP
//                                   (DECODE -> FETCH), trap tied 0
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   inscod     in   opcode IR[31:26], valid from DECODE onward
//   alu_zero   in   ALU result == 0
//   alu_neg    in   ALU result sign bit
//   mem_ready  in   memory access completes this cycle
//   PCWrite    out  PC load enable (branch condition already resolved)
//   IorD       out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead    out  memory read strobe
//   MemWrite   out  memory write strobe
//   IRWrite    out  IR load enable
//   Memtoreg   out  writeback source: 1 = MDR, 0 = ALUOut
//   RegDist    out  destination register: 1 = rd, 0 = rt
//   Regwrite   out  register-file write enable
//   ALUsrcA    out  ALU A operand: 0 = PC, 1 = rs
//   ALUsrcB    out  ALU B operand: 00 rt, 01 const 4, 10 imm, 11 imm<<2
//   ALUop      out  ALU function code
//   PCSource   out  PC source: 00 ALU result, 01 ALUOut, 10 jump target
//   busy       out  high in every state except FETCH
//   trap       out  illegal-opcode indication
//   dbg_state  out  current state code
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int unsigned ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      inscod,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            Memtoreg,
    output logic            RegDist,
    output logic            Regwrite,
    output logic            ALUsrcA,
    output logic [1:0]      ALUsrcB,
    output logic [3:0]      ALUop,
    output logic [1:0]      PCSource,
    output logic            busy,
    output logic            trap,
    output logic [ST_W-1:0] dbg_state
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StRwb    = 4'd7,
        StExecI  = 4'd8,
        StIwb    = 4'd9,
        StBranch = 4'd10,
        StJump   = 4'd11,
        StHalt   = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpBgtz  = 6'b000111;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [3:0] AluAdd  = 4'b0001;

    state_e     state_q;
    logic [5:0] op_q;     // opcode captured when leaving DECODE

    // Dispatch target out of DECODE for a given opcode.
    function automatic state_e decode_target(input logic [5:0] op);
        state_e nxt;
        case (op)
            OpRtype:                        nxt = StExecR;
            OpLw, OpSw:                     nxt = StMemAdr;
            OpAddi, OpAndi, OpOri, OpSlti:  nxt = StExecI;
            OpBeq, OpBne, OpBgtz:           nxt = StBranch;
            OpJ:                            nxt = StJump;
`ifdef MC_ILLEGAL_TRAP_EN
            default:                        nxt = StHalt;
`else
            default:                        nxt = StFetch;
`endif
        endcase
        return nxt;
    endfunction

    // State register plus opcode latch; next-state is resolved in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= '0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) state_q <= StDecode;
                end
                StDecode: begin
                    op_q    <= inscod;
                    state_q <= decode_target(inscod);
                end
                StMemAdr: state_q <= (op_q == OpLw) ? StMemRd : StMemWr;
                StMemRd: begin
                    if (mem_ready) state_q <= StMemWb;
                end
                StMemWb:  state_q <= StFetch;
                StMemWr: begin
                    if (mem_ready) state_q <= StFetch;
                end
                StExecR:  state_q <= StRwb;
                StRwb:    state_q <= StFetch;
                StExecI:  state_q <= StIwb;
                StIwb:    state_q <= StFetch;
                StBranch: state_q <= StFetch;
                StJump:   state_q <= StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
                StHalt:   state_q <= StHalt;
`else
                StHalt:   state_q <= StFetch;
`endif
                default:  state_q <= StFetch;
            endcase
        end
    end

    // Moore outputs. FETCH strobes are qualified by mem_ready and the branch
    // PC load by the ALU flags; nothing looks at inscod directly.
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        Memtoreg = 1'b0;
        RegDist  = 1'b0;
        Regwrite = 1'b0;
        ALUsrcA  = 1'b0;
        ALUsrcB  = 2'b00;
        ALUop    = AluAdd;
        PCSource = 2'b00;
        trap     = 1'b0;

        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUsrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            StDecode: begin
                ALUsrcB = 2'b11;
            end
            StMemAdr: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
                ALUop   = (op_q == OpLw) ? 4'b1000 : 4'b0100;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                Regwrite = 1'b1;
                Memtoreg = 1'b1;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            StExecR: begin
                ALUsrcA = 1'b1;
                ALUop   = 4'b0111;
            end
            StRwb: begin
                Regwrite = 1'b1;
                RegDist  = 1'b1;
            end
            StExecI: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
                case (op_q)
                    OpAndi:  ALUop = 4'b0000;
                    OpOri:   ALUop = 4'b0010;
                    OpSlti:  ALUop = 4'b0011;
                    default: ALUop = AluAdd;
                endcase
            end
            StIwb: begin
                Regwrite = 1'b1;
            end
            StBranch: begin
                ALUsrcA  = 1'b1;
                PCSource = 2'b01;
                case (op_q)
                    OpBne: begin
                        ALUop   = 4'b0110;
                        PCWrite = ~alu_zero;
                    end
                    OpBgtz: begin
                        ALUop   = 4'b1001;
                        PCWrite = ~alu_zero & ~alu_neg;
                    end
                    default: begin
                        ALUop   = 4'b0101;
                        PCWrite = alu_zero;
                    end
                endcase
            end
            StJump: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            StHalt: begin
`ifdef MC_ILLEGAL_TRAP_EN
                trap = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != StFetch);
    assign dbg_state = ST_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Self-checking bench for mc_control_fsm. Each instruction is expanded into
// its expected list of (state, mem_ready) cycles from the instruction class,
// and the outputs expected in each cycle come from the control table.
// Directed cases come first, then randomized instructions.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] inscod;
    logic       alu_zero, alu_neg, mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, Memtoreg, RegDist, Regwrite;
    logic       ALUsrcA;
    logic [1:0] ALUsrcB;
    logic [3:0] ALUop;
    logic [1:0] PCSource;
    logic       busy, trap;
    logic [3:0] dbg_state;

    mc_control_fsm #(.ST_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .inscod    (inscod),
        .alu_zero  (alu_zero),
        .alu_neg   (alu_neg),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .Memtoreg  (Memtoreg),
        .RegDist   (RegDist),
        .Regwrite  (Regwrite),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ALUop     (ALUop),
        .PCSource  (PCSource),
        .busy      (busy),
        .trap      (trap),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BGTZ = 6'b000111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    int checks = 0;
    int errors = 0;
    int irw_cnt, rw_cnt, mw_cnt;

    logic [18:0] obs;
    assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, Memtoreg, RegDist, Regwrite,
                  ALUsrcA, ALUsrcB, ALUop, PCSource, busy, trap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_lw(input logic [5:0] op);  return op == OP_LW;  endfunction
    function automatic bit is_sw(input logic [5:0] op);  return op == OP_SW;  endfunction
    function automatic bit is_imm(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
    endfunction
    function automatic bit is_br(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BGTZ};
    endfunction
    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || is_lw(op) || is_sw(op) || is_imm(op) || is_br(op) || op == OP_J;
    endfunction

    // Expected control word for one cycle, straight from the control table.
    function automatic logic [18:0] exp_out(input int st, input logic [5:0] op,
                                            input logic rdy, input logic z, input logic n);
        logic pcw = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0;
        logic srca = 0, trp = 0;
        logic [1:0] srcb = 2'b00, pcs = 2'b00;
        logic [3:0] aop = 4'b0001;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; aop = is_lw(op) ? 4'b1000 : 4'b0100; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 4'b0111; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin
                srca = 1; srcb = 2'b10;
                aop = (op == OP_ANDI) ? 4'b0000 : (op == OP_ORI) ? 4'b0010 :
                      (op == OP_SLTI) ? 4'b0011 : 4'b0001;
            end
            9:  rw = 1;
            10: begin
                srca = 1; pcs = 2'b01;
                if (op == OP_BEQ)      begin aop = 4'b0101; pcw = z; end
                else if (op == OP_BNE) begin aop = 4'b0110; pcw = !z; end
                else                   begin aop = 4'b1001; pcw = !z && !n; end
            end
            11: begin pcs = 2'b10; pcw = 1; end
            12: trp = 1;
            default: ;
        endcase
        return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs,
                logic'(st != 0), trp};
    endfunction

    // One clock: drive inputs, sample at negedge, then advance past posedge.
    task automatic step(input int st, input logic rdy, input logic [5:0] op,
                        input logic z, input logic n);
        mem_ready = rdy;
        inscod    = (st == 1) ? op : 6'($urandom);
        alu_zero  = (st == 10) ? z : 1'($urandom);
        alu_neg   = (st == 10) ? n : 1'($urandom);
        @(negedge clk);
        check("state", 32'(dbg_state), 32'(st));
        check("outputs", 32'(obs), 32'(exp_out(st, op, rdy, z, n)));
        if (IRWrite)  irw_cnt++;
        if (Regwrite) rw_cnt++;
        if (MemWrite) mw_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_outputs", 32'(obs), 32'(exp_out(0, 6'd0, 1'b0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle list and run it.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input logic z, input logic n);
        int st_q[$];
        bit rd_q[$];
        irw_cnt = 0; rw_cnt = 0; mw_cnt = 0;
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); rd_q.push_back(0); end
        st_q.push_back(0); rd_q.push_back(1);
        st_q.push_back(1); rd_q.push_back(1'($urandom));
        if (is_lw(op)) begin
            st_q.push_back(2); rd_q.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin st_q.push_back(3); rd_q.push_back(0); end
            st_q.push_back(3); rd_q.push_back(1);
            st_q.push_back(4); rd_q.push_back(1'($urandom));
        end else if (is_sw(op)) begin
            st_q.push_back(2); rd_q.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin st_q.push_back(5); rd_q.push_back(0); end
            st_q.push_back(5); rd_q.push_back(1);
        end else if (op == OP_R) begin
            st_q.push_back(6); st_q.push_back(7);
            rd_q.push_back(1'($urandom)); rd_q.push_back(1'($urandom));
        end else if (is_imm(op)) begin
            st_q.push_back(8); st_q.push_back(9);
            rd_q.push_back(1'($urandom)); rd_q.push_back(1'($urandom));
        end else if (is_br(op)) begin
            st_q.push_back(10); rd_q.push_back(1'($urandom));
        end else if (op == OP_J) begin
            st_q.push_back(11); rd_q.push_back(1'($urandom));
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++) begin st_q.push_back(12); rd_q.push_back(1'($urandom)); end
`endif
        end
        for (int k = 0; k < st_q.size(); k++) step(st_q[k], rd_q[k], op, z, n);
        check("irwrite_pulses", 32'(irw_cnt), 32'd1);
        check("regwrite_cycles", 32'(rw_cnt),
              (is_lw(op) || is_imm(op) || op == OP_R) ? 32'd1 : 32'd0);
        check("memwrite_cycles", 32'(mw_cnt), is_sw(op) ? 32'(mw + 1) : 32'd0);
        if (!is_legal(op)) begin
`ifdef MC_ILLEGAL_TRAP_EN
            check("halt_trap", 32'(trap), 32'd1);
            do_reset();
`else
            check("nop_trap", 32'(trap), 32'd0);
`endif
        end
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
                OP_BEQ, OP_BNE, OP_BGTZ, OP_J};
        rst = 1'b1; inscod = '0; alu_zero = 0; alu_neg = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Directed cases
        run_instr(OP_ADDI, 0, 0, 0, 0);
        run_instr(OP_LW,   3, 2, 0, 0);
        run_instr(OP_BEQ,  0, 0, 1, 0);
        run_instr(OP_BEQ,  0, 0, 0, 0);
        run_instr(OP_BGTZ, 0, 0, 0, 1);
        run_instr(OP_BGTZ, 0, 0, 0, 0);
        run_instr(OP_BAD,  1, 0, 0, 0);

        // sw with reset during the MEMWR wait
        irw_cnt = 0; rw_cnt = 0; mw_cnt = 0;
        step(0, 1, OP_SW, 0, 0);
        step(1, 0, OP_SW, 0, 0);
        step(2, 0, OP_SW, 0, 0);
        step(5, 0, OP_SW, 0, 0);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_wait_state", 32'(dbg_state), 32'd5);
        check("sw_wait_memwrite", 32'(MemWrite), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("sw_rst_state", 32'(dbg_state), 32'd0);
        check("sw_rst_memwrite", 32'(MemWrite), 32'd0);
        @(posedge clk);
        #1;

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 10)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath.
- Replaces single-cycle opcode decoding with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared ALU, the unified instruction/data memory port, the IR, the register file and the PC.
- Stalls on a memory-ready handshake; the ALU opcode encoding is identical to the single-cycle control unit.

Parameters:
- ST_W, 4, width of the state encoding (exported on dbg_state).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- inscod  in  6  opcode field IR[31:26], valid from DECODE onward
- alu_zero  in  1  ALU result == 0
- alu_neg  in  1  ALU result sign bit
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC load enable (unconditional or branch taken, already resolved)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- Memtoreg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- RegDist  out  1  destination register: 1 = rd, 0 = rt
- Regwrite  out  1  register-file write enable
- ALUsrcA  out  1  ALU A operand: 0 = PC, 1 = rs
- ALUsrcB  out  2  ALU B operand: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUop  out  4  ALU function code
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- busy  out  1  high in every state except FETCH
- trap  out  1  illegal-opcode indication
- dbg_state  out  ST_W  current state code

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RWB=7, EXEC_I=8, IWB=9, BRANCH=10, JUMP=11, HALT=12.
- rst high at a clock edge: state <= FETCH. Takes effect from any state, including mid-memory-wait.
- Outputs are purely combinational from state (Moore); no output depends on inscod combinationally.
- Every output defaults to 0 except ALUop, which defaults to 4'b0001. After reset every output is 0, except ALUop=0001 and the FETCH strobes listed below.
- FETCH:
  - MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=0001, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUsrcA=0, ALUsrcB=11, ALUop=0001 (branch target computed into ALUOut).
  - Next state by inscod: 000000 -> EXEC_R; 100011 or 101011 -> MEMADR; 001000, 001100, 001101, 001010 -> EXEC_I; 000100, 000101, 000111 -> BRANCH; 000010 -> JUMP; any other opcode -> illegal handling (see Optional Feature).
- MEMADR:
  - ALUsrcA=1, ALUsrcB=10.
  - ALUop=1000 for lw, 0100 for sw.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold while mem_ready=0, then -> MEMWB.
- MEMWB: Regwrite=1, Memtoreg=1, RegDist=0. -> FETCH.
- MEMWR:
  - MemWrite=1, IorD=1.
  - Hold while mem_ready=0, then -> FETCH.
  - MemWrite stays asserted throughout the wait.
- EXEC_R: ALUsrcA=1, ALUsrcB=00, ALUop=0111. -> RWB.
- RWB: Regwrite=1, RegDist=1, Memtoreg=0. -> FETCH.
- EXEC_I:
  - ALUsrcA=1, ALUsrcB=10.
  - ALUop: addi=0001, andi=0000, ori=0010, slti=0011.
  - -> IWB.
- IWB: Regwrite=1, RegDist=0, Memtoreg=0. -> FETCH.
- BRANCH:
  - ALUsrcA=1, ALUsrcB=00, PCSource=01.
  - ALUop: beq=0101, bne=0110, bgtz=1001.
  - PCWrite=1 when taken:
    - beq taken when alu_zero=1.
    - bne taken when alu_zero=0.
    - bgtz taken when alu_zero=0 and alu_neg=0.
  - -> FETCH.
- JUMP: PCSource=10, PCWrite=1. -> FETCH.
- The opcode is latched into an internal register on the DECODE->next transition. Later states use the latched copy, so inscod may change after DECODE.
- Instruction latency excluding memory waits:
  - lw: 5 cycles.
  - R-type, I-type ALU and sw: 4 cycles.
  - Branch and jump: 3 cycles.
- busy=0 only in FETCH.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE -> HALT.
  - In HALT: trap=1, all strobes 0.
  - HALT is left only by rst.
- Undefined:
  - An illegal opcode is executed as a NOP: DECODE -> FETCH, no register or memory write.
  - HALT is unreachable and trap is tied 0.

Test Plan:
- Reset then addi (inscod=001000), mem_ready=1 always -> state sequence 0,1,8,9,0. ALUop=0001 in EXEC_I. Regwrite=1 only in IWB.
- lw (100011) with mem_ready low 3 cycles in FETCH and 2 cycles in MEMRD -> total 10 cycles. IRWrite pulses exactly once. Regwrite+Memtoreg asserted in MEMWB only.
- beq with alu_zero=1 -> PCWrite=1, PCSource=01 in BRANCH. Repeat with alu_zero=0 -> PCWrite=0.
- bgtz (000111) with alu_neg=1, alu_zero=0 -> not taken; with alu_neg=0, alu_zero=0 -> taken. ALUop=1001 in both cases.
- Opcode 111111 -> with MC_ILLEGAL_TRAP_EN: state 12, trap=1 until rst. Without the macro: back to FETCH after 2 cycles, no write strobe.
- sw (101011) with rst asserted during the MEMWR wait -> next cycle is FETCH and MemWrite=0.
